obstacle_pool: RTL and testbench
================================

# obstacle_pool

Parametrised obstacle manager for the runner game: owns a pool of `NUM_SLOTS` obstacle slots, raises difficulty (allowed-active count and scroll speed) from `time_alive`, spawns obstacles into free slots after a random tick delay, and scrolls all active obstacles left once per frame tick. It sits between the game-state/timer logic and the renderer/collision checker. Supersedes the fixed 10-slot ring-index generator: spawn allocation is lowest-free-slot, any number of slots may retire in one cycle, and the spawn timer is internal.

## Interface
Parameters:
- `NUM_SLOTS`, 10, pool size (1..15)
- `NUM_LANES`, 3, valid lanes 0..NUM_LANES-1 (2..4)
- `SPAWN_POS`, 11'd1087, position loaded on spawn and on retire
- `LEVEL_PERIOD`, 300, `time_alive` units per difficulty level
- `MAX_SPEED`, 7, speed ceiling (3-bit)

Ports (one clock; reset is synchronous and active-high):
- `clk_in` input 1 system clock
- `rst_in` input 1 synchronous active-high reset
- `game_reset` input 1 synchronous clear, identical effect to `rst_in`
- `tick_in` input 1 one-cycle frame strobe; movement and spawn delay advance only on it
- `pause_in` input 1 freezes movement, delay counter and level updates
- `time_alive` input 12 elapsed game time
- `random_num` input 4 spawn delay seed
- `random_lane` input 2 requested lane
- `random_sprite` input 2 sprite type
- `obstacles_out` output `obstacle` x NUM_SLOTS slot array (lane, position[10:0], sprite_type, active)
- `active_count` output 4 number of active slots
- `level` output 4 current difficulty level
- `speed` output 3 pixels per tick
- `spawn_pulse` output 1 high for the cycle after a spawn commit

## Operation
- Reset (`rst_in` or `game_reset`): every slot active=0, position=SPAWN_POS, lane=0, sprite=0; `active_count`=0, `level`=0, `speed`=1, `spawn_pulse`=0, threshold register=LEVEL_PERIOD, FSM=IDLE. Reset wins over all other inputs.
- Level: when not paused, if `time_alive` >= threshold and `level` < NUM_SLOTS: `level`+1, threshold+=LEVEL_PERIOD. At most one step per cycle. `speed` = min(level+1, MAX_SPEED), registered with `level`.
- Movement (on `tick_in` && !`pause_in`), per active slot independently: if position <= speed → active=0, position=SPAWN_POS (retire); else position -= speed. Inactive slots unchanged.
- Spawn FSM:
  - IDLE: if `active_count` < `level` → load delay = `random_num`+1 (5-bit), go WAIT.
  - WAIT: on unpaused tick, delay-1; when delay reaches 0 → SPAWN.
  - SPAWN: select lowest-index slot inactive at the start of this cycle; write active=1, position=SPAWN_POS, lane=`random_lane` (values >= NUM_LANES map to 0), sprite=`random_sprite`; go IDLE. No free slot → remain in SPAWN.
- `active_count` next = current + spawn(0/1) − number of retires this cycle.
- A slot retiring in the same cycle is not eligible for the spawn that cycle. A freshly spawned slot is not moved in its spawn cycle even if `tick_in` is high.
- `pause_in` does not block a SPAWN-state commit.

## Timing
- All outputs registered; slot updates visible the cycle after the `tick_in` or SPAWN cycle.
- Spawn latency from IDLE entry: 1 cycle to WAIT, `random_num`+1 ticks, 1 cycle in SPAWN; `spawn_pulse` asserts the following cycle.
- Level tracks a `time_alive` jump of N periods in N cycles.
- Reset mid-WAIT or mid-SPAWN aborts; no partial slot write.

## Test plan
- Reset, `time_alive`=0, 50 ticks → no slot active, `level`=0, `speed`=1, `active_count`=0.
- `time_alive`=300, `random_num`=2, `random_lane`=1 → `level`=1, `speed`=2; slot 0 active lane 1 position 1087 after 3 ticks; position 1085 after next tick; `spawn_pulse` one cycle.
- `random_lane`=3 on spawn → lane 0 written.
- Two slots at position 2, `speed`=2, one tick → both retire same cycle, `active_count` drops by 2, positions 1087.
- `time_alive`=3300 → `level` walks 1..10 over 10 cycles, `speed` saturates at 7; pool fills to 10; 11th request holds in SPAWN until a retire, then fills lowest freed slot.
- `pause_in` high for 20 ticks mid-WAIT → positions and delay frozen; `game_reset` pulse → all outputs at reset values next cycle.

Source files
------------

// File: rtl/obstacle_pool.sv
// Obstacle pool for the runner game: difficulty ramp, timed spawning into the
// lowest free slot, and per-tick leftward scrolling of every active obstacle.
package obstacle_pool_pkg;
  typedef struct packed {
    logic [1:0]  lane;
    logic [10:0] position;
    logic [1:0]  sprite_type;
    logic        active;
  } obstacle_t;
endpackage

module obstacle_pool
  import obstacle_pool_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 10,
  parameter int unsigned NUM_LANES    = 3,
  parameter logic [10:0] SPAWN_POS    = 11'd1087,
  parameter int unsigned LEVEL_PERIOD = 300,
  parameter int unsigned MAX_SPEED    = 7
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      game_reset,
  input  logic                      tick_in,
  input  logic                      pause_in,
  input  logic [11:0]               time_alive,
  input  logic [3:0]                random_num,
  input  logic [1:0]                random_lane,
  input  logic [1:0]                random_sprite,
  output obstacle_t [NUM_SLOTS-1:0] obstacles_out,
  output logic [3:0]                active_count,
  output logic [3:0]                level,
  output logic [2:0]                speed,
  output logic                      spawn_pulse
);

  localparam logic [3:0]  NUM_SLOTS_L = 4'(NUM_SLOTS);
  localparam logic [2:0]  NUM_LANES_L = 3'(NUM_LANES);
  localparam logic [15:0] PERIOD_L    = 16'(LEVEL_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SPAWN
  } state_t;

  function automatic logic [2:0] speed_sat(input logic [3:0] lvl);
    logic [4:0] s;
    s = {1'b0, lvl} + 5'd1;
    if (s > 5'(MAX_SPEED)) return 3'(MAX_SPEED);
    return s[2:0];
  endfunction

  function automatic logic [1:0] lane_map(input logic [1:0] req);
    if ({1'b0, req} >= NUM_LANES_L) return 2'd0;
    return req;
  endfunction

  state_t                    state_q, state_d;
  logic [4:0]                delay_q, delay_d;
  obstacle_t [NUM_SLOTS-1:0] slots_q, slots_d;
  logic [3:0]                count_q, count_d;
  logic [3:0]                level_q, level_d;
  logic [2:0]                speed_q, speed_d;
  logic [15:0]               thresh_q, thresh_d;
  logic                      pulse_q, pulse_d;

  logic                      step;
  logic                      found;
  logic [3:0]                spawn_idx;
  logic [3:0]                n_retire;
  logic                      spawn_go;

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    slots_d   = slots_q;
    level_d   = level_q;
    speed_d   = speed_q;
    thresh_d  = thresh_q;
    found     = 1'b0;
    spawn_idx = '0;
    n_retire  = '0;
    spawn_go  = 1'b0;
    step      = tick_in && !pause_in;

    if (!pause_in && ({4'b0, time_alive} >= thresh_q) && (level_q < NUM_SLOTS_L)) begin
      level_d  = level_q + 4'd1;
      thresh_d = thresh_q + PERIOD_L;
      speed_d  = speed_sat(level_d);
    end

    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (step && slots_q[i].active) begin
        if (slots_q[i].position <= {8'b0, speed_q}) begin
          slots_d[i].active   = 1'b0;
          slots_d[i].position = SPAWN_POS;
          n_retire            = n_retire + 4'd1;
        end else begin
          slots_d[i].position = slots_q[i].position - {8'b0, speed_q};
        end
      end
    end

    // Descending scan so the lowest free index is the one left standing.
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!slots_q[i].active) begin
        found     = 1'b1;
        spawn_idx = 4'(i);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (count_q < level_q) begin
          delay_d = {1'b0, random_num} + 5'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (step) begin
          delay_d = delay_q - 5'd1;
          if (delay_q <= 5'd1) state_d = S_SPAWN;
        end
      end
      S_SPAWN: begin
        if (found) begin
          spawn_go                       = 1'b1;
          slots_d[spawn_idx].active      = 1'b1;
          slots_d[spawn_idx].position    = SPAWN_POS;
          slots_d[spawn_idx].lane        = lane_map(random_lane);
          slots_d[spawn_idx].sprite_type = random_sprite;
          state_d                        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pulse_d = spawn_go;
    count_d = count_q + {3'b0, spawn_go} - n_retire;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || game_reset) begin
      state_q  <= S_IDLE;
      delay_q  <= '0;
      count_q  <= '0;
      level_q  <= '0;
      speed_q  <= 3'd1;
      thresh_q <= PERIOD_L;
      pulse_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slots_q[i].active      <= 1'b0;
        slots_q[i].position    <= SPAWN_POS;
        slots_q[i].lane        <= 2'd0;
        slots_q[i].sprite_type <= 2'd0;
      end
    end else begin
      state_q  <= state_d;
      delay_q  <= delay_d;
      count_q  <= count_d;
      level_q  <= level_d;
      speed_q  <= speed_d;
      thresh_q <= thresh_d;
      pulse_q  <= pulse_d;
      slots_q  <= slots_d;
    end
  end

  assign obstacles_out = slots_q;
  assign active_count  = count_q;
  assign level         = level_q;
  assign speed         = speed_q;
  assign spawn_pulse   = pulse_q;

endmodule

// File: tb/tb_obstacle_pool.sv
// Scoreboard bench for obstacle_pool: a per-cycle behavioural model pushes the
// expected outputs, a monitor pops and compares one cycle later.
module tb_obstacle_pool;
  import obstacle_pool_pkg::*;

  localparam int N = 10;

  logic             clk_in = 1'b0;
  logic             rst_in, game_reset, tick_in, pause_in;
  logic [11:0]      time_alive;
  logic [3:0]       random_num;
  logic [1:0]       random_lane, random_sprite;
  obstacle_t [N-1:0] obstacles_out;
  logic [3:0]       active_count, level;
  logic [2:0]       speed;
  logic             spawn_pulse;

  always #5 clk_in = ~clk_in;

  obstacle_pool dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .game_reset   (game_reset),
    .tick_in      (tick_in),
    .pause_in     (pause_in),
    .time_alive   (time_alive),
    .random_num   (random_num),
    .random_lane  (random_lane),
    .random_sprite(random_sprite),
    .obstacles_out(obstacles_out),
    .active_count (active_count),
    .level        (level),
    .speed        (speed),
    .spawn_pulse  (spawn_pulse)
  );

  typedef struct {
    int cnt;
    int lvl;
    int spd;
    int pulse;
    obstacle_t [N-1:0] obs;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int m_act[N], m_pos[N], m_lane[N], m_spr[N];
  int m_level, m_thresh, m_mode, m_delay, m_pulse;
  int fix_num = -1;
  int fix_lane = -1;

  function automatic int min_speed(input int lvl);
    return (lvl + 1 < 7) ? lvl + 1 : 7;
  endfunction

  task automatic model_step(input bit r, input bit tk, input bit ps, input int ta,
                            input int rn, input int rl, input int rs);
    int cnt, free, spd, old_level;
    bit stp;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_pos[i] = 1087; m_lane[i] = 0; m_spr[i] = 0;
      end
      m_level = 0; m_thresh = 300; m_mode = 0; m_delay = 0; m_pulse = 0;
      return;
    end
    stp = tk && !ps;
    cnt = 0;
    free = -1;
    for (int i = 0; i < N; i++) begin
      cnt += m_act[i];
      if (m_act[i] == 0 && free < 0) free = i;
    end
    spd = min_speed(m_level);
    old_level = m_level;
    if (!ps && ta >= m_thresh && m_level < N) begin
      m_level++;
      m_thresh += 300;
    end
    if (stp) begin
      for (int i = 0; i < N; i++) begin
        if (m_act[i] != 0) begin
          if (m_pos[i] <= spd) begin
            m_act[i] = 0; m_pos[i] = 1087;
          end else begin
            m_pos[i] -= spd;
          end
        end
      end
    end
    m_pulse = 0;
    case (m_mode)
      0: if (cnt < old_level) begin m_delay = rn + 1; m_mode = 1; end
      1: if (stp) begin m_delay--; if (m_delay == 0) m_mode = 2; end
      default: if (free >= 0) begin
        m_act[free] = 1; m_pos[free] = 1087;
        m_lane[free] = (rl < 3) ? rl : 0;
        m_spr[free] = rs; m_pulse = 1; m_mode = 0;
      end
    endcase
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt = 0;
    for (int i = 0; i < N; i++) begin
      e.cnt += m_act[i];
      e.obs[i].active      = (m_act[i] != 0);
      e.obs[i].position    = 11'(m_pos[i]);
      e.obs[i].lane        = 2'(m_lane[i]);
      e.obs[i].sprite_type = 2'(m_spr[i]);
    end
    e.lvl = m_level;
    e.spd = min_speed(m_level);
    e.pulse = m_pulse;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  task automatic drive(input bit r, input bit gr, input bit tk, input bit ps, input int ta);
    int rn, rl, rs;
    @(negedge clk_in);
    rn = (fix_num >= 0) ? fix_num : int'($urandom_range(0, 15));
    rl = (fix_lane >= 0) ? fix_lane : int'($urandom_range(0, 3));
    rs = int'($urandom_range(0, 3));
    rst_in = r; game_reset = gr; tick_in = tk; pause_in = ps;
    time_alive = 12'(ta);
    random_num = 4'(rn); random_lane = 2'(rl); random_sprite = 2'(rs);
    model_step(r || gr, tk, ps, ta, rn, rl, rs);
    exp_q.push_back(snapshot());
  endtask

  // Monitor: outputs settle just after the edge that consumed the stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("active_count", 32'(active_count), 32'(e.cnt));
        chk("level", 32'(level), 32'(e.lvl));
        chk("speed", 32'(speed), 32'(e.spd));
        chk("spawn_pulse", 32'(spawn_pulse), 32'(e.pulse));
        for (int i = 0; i < N; i++)
          chk($sformatf("slot%0d", i), 32'(obstacles_out[i]), 32'(e.obs[i]));
      end
    end
  end

  initial begin
    int ta;
    rst_in = 1'b1; game_reset = 1'b0; tick_in = 1'b0; pause_in = 1'b0;
    time_alive = '0; random_num = '0; random_lane = '0; random_sprite = '0;

    repeat (3) drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) drive(0, 0, (i % 2) == 0, 0, 0);

    fix_num = 2; fix_lane = 1;
    for (int i = 0; i < 80; i++) drive(0, 0, (i % 3) == 0, 0, 300);
    fix_lane = 3;
    for (int i = 0; i < 80; i++) drive(0, 0, (i % 3) == 0, 0, 300);
    fix_num = 9; fix_lane = -1;
    for (int i = 0; i < 6; i++) drive(0, 0, (i % 2) == 0, 0, 300);
    for (int i = 0; i < 40; i++) drive(0, 0, (i % 2) == 0, 1, 300);
    fix_num = -1;
    drive(0, 1, 1, 0, 300);
    drive(0, 0, 0, 0, 0);

    for (int i = 0; i < 4000; i++)
      drive(0, 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, 3300);

    ta = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) ta = int'($urandom_range(0, 4095));
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 299) == 0,
            $urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0, ta);
    end

    repeat (2) @(posedge clk_in);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
